// File: rtl/ppm_frame_ctrl.sv
// Frame sequencer for the PPM transmitter: SOF trigger, payload bytes split into
// MSB-first PPM symbols, EOF trigger, with a per-wait watchdog that aborts stalled frames.
module ppm_frame_ctrl #(
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TMR_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [7:0]       tx_len,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             sof_start,
  input  logic             sof_done,
  output logic             sym_start,
  output logic [SYM_W-1:0] sym_data,
  input  logic             sym_done,
  output logic             eof_start,
  input  logic             eof_done,
  output logic             busy,
  output logic             tx_done,
  output logic             len_err,
  output logic             timeout_err
);

  localparam int unsigned NSym = 8 / SYM_W;
  localparam int unsigned IdxW = (NSym > 1) ? $clog2(NSym) : 1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NSym - 1);
  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle, StSofReq, StSofWait, StFetch, StSymReq, StSymWait, StEofReq, StEofWait, StDone
  } state_e;

  state_e          state_q;
  logic [7:0]      bytes_left_q;
  logic [7:0]      byte_q;
  logic [IdxW-1:0] sym_idx_q;
  logic [TMR_W-1:0] tmr_q;

  logic in_wait;
  logic wait_go;

  always_comb begin
    in_wait = 1'b0;
    wait_go = 1'b0;
    unique case (state_q)
      StSofWait: begin in_wait = 1'b1; wait_go = sof_done;   end
      StFetch:   begin in_wait = 1'b1; wait_go = byte_valid; end
      StSymWait: begin in_wait = 1'b1; wait_go = sym_done;   end
      StEofWait: begin in_wait = 1'b1; wait_go = eof_done;   end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bytes_left_q <= '0;
      byte_q       <= '0;
      sym_idx_q    <= '0;
      tmr_q        <= '0;
      byte_ready   <= 1'b0;
      sof_start    <= 1'b0;
      sym_start    <= 1'b0;
      sym_data     <= '0;
      eof_start    <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      len_err      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sof_start   <= 1'b0;
      sym_start   <= 1'b0;
      eof_start   <= 1'b0;
      tx_done     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      // Request states always lead into a wait, so the watchdog starts from zero there.
      tmr_q       <= in_wait ? tmr_q + 1'b1 : '0;

      unique case (state_q)
        StIdle: begin
          if (tx_start) begin
            if (tx_len != 8'd0) begin
              bytes_left_q <= tx_len;
              sof_start    <= 1'b1;
              busy         <= 1'b1;
              state_q      <= StSofReq;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        StSofReq: state_q <= StSofWait;
        StSofWait: begin
          if (sof_done) begin
            byte_ready <= 1'b1;
            tmr_q      <= '0;
            state_q    <= StFetch;
          end
        end
        StFetch: begin
          if (byte_valid) begin
            byte_ready <= 1'b0;
            sym_data   <= byte_data[7 -: SYM_W];
            byte_q     <= byte_data << SYM_W;
            sym_idx_q  <= '0;
            sym_start  <= 1'b1;
            state_q    <= StSymReq;
          end
        end
        StSymReq: state_q <= StSymWait;
        StSymWait: begin
          if (sym_done) begin
            if (sym_idx_q != LastIdx) begin
              sym_idx_q <= sym_idx_q + 1'b1;
              sym_data  <= byte_q[7 -: SYM_W];
              byte_q    <= byte_q << SYM_W;
              sym_start <= 1'b1;
              state_q   <= StSymReq;
            end else begin
              bytes_left_q <= bytes_left_q - 8'd1;
              if (bytes_left_q == 8'd1) begin
                eof_start <= 1'b1;
                state_q   <= StEofReq;
              end else begin
                byte_ready <= 1'b1;
                tmr_q      <= '0;
                state_q    <= StFetch;
              end
            end
          end
        end
        StEofReq: state_q <= StEofWait;
        StEofWait: begin
          if (eof_done) begin
            tx_done <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // A done/valid arriving in the expiry cycle takes precedence over the abort.
      if (in_wait && !wait_go && (tmr_q == TmrLast)) begin
        timeout_err <= 1'b1;
        byte_ready  <= 1'b0;
        busy        <= 1'b0;
        state_q     <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_ppm_frame_ctrl.sv
// Randomized and directed bench for ppm_frame_ctrl; downstream blocks and the byte source
// are behavioural responders, expected symbols and timings come from arithmetic on the frame.
module tb_ppm_frame_ctrl;

  localparam int unsigned SymW    = 2;
  localparam int unsigned Timeout = 1023;

  logic            clk = 1'b0;
  logic            rst;
  logic            tx_start;
  logic [7:0]      tx_len;
  logic [7:0]      byte_data;
  logic            byte_valid;
  logic            byte_ready;
  logic            sof_start, sof_done;
  logic            sym_start, sym_done;
  logic [SymW-1:0] sym_data;
  logic            eof_start, eof_done;
  logic            busy, tx_done, len_err, timeout_err;

  ppm_frame_ctrl #(.SYM_W(SymW), .TIMEOUT(Timeout), .TMR_W(10)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_len(tx_len),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .sof_start(sof_start), .sof_done(sof_done),
    .sym_start(sym_start), .sym_data(sym_data), .sym_done(sym_done),
    .eof_start(eof_start), .eof_done(eof_done),
    .busy(busy), .tx_done(tx_done), .len_err(len_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, busy, byte_ready, sof_start, sym_start, sym_data, eof_start, tx_done,
            len_err, timeout_err};
  endfunction

  // Responder / source configuration (written by the main sequence only).
  int sof_dmin = 0, sof_dmax = 0, sym_dmin = 0, sym_dmax = 0, eof_dmin = 0, eof_dmax = 0;
  int sp_idx = -1, sp_delay = 0;
  bit sp_hold = 1'b0;
  int src_gap = 0;
  bit src_flush = 1'b0;
  logic [7:0] src_q[$];

  // SOF / EOF generators: pulse done after a random number of cycles in the wait state.
  int sof_d, eof_d;
  initial begin
    sof_done = 1'b0;
    forever begin
      @(negedge clk);
      if (sof_start) begin
        sof_d = $urandom_range(sof_dmax, sof_dmin);
        @(posedge clk);
        repeat (sof_d) @(posedge clk);
        #1 sof_done = 1'b1;
        @(posedge clk);
        #1 sof_done = 1'b0;
      end
    end
  end

  initial begin
    eof_done = 1'b0;
    forever begin
      @(negedge clk);
      if (eof_start) begin
        eof_d = $urandom_range(eof_dmax, eof_dmin);
        @(posedge clk);
        repeat (eof_d) @(posedge clk);
        #1 eof_done = 1'b1;
        @(posedge clk);
        #1 eof_done = 1'b0;
      end
    end
  end

  int sym_seen = 0;
  int sym_d;
  bit sym_skip;
  initial begin
    sym_done = 1'b0;
    forever begin
      @(negedge clk);
      if (sym_start) begin
        sym_d    = $urandom_range(sym_dmax, sym_dmin);
        sym_skip = 1'b0;
        if (sym_seen == sp_idx) begin
          if (sp_hold) sym_skip = 1'b1;
          else         sym_d = sp_delay;
        end
        sym_seen++;
        if (!sym_skip) begin
          @(posedge clk);
          repeat (sym_d) @(posedge clk);
          #1 sym_done = 1'b1;
          @(posedge clk);
          #1 sym_done = 1'b0;
        end
      end
    end
  end

  // Byte source: presents queued bytes in order, optionally after a gap of idle cycles.
  int src_rd = 0;
  initial begin
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1 byte_valid = 1'b0;
      if (src_flush) begin
        src_rd = src_q.size();
      end else if (src_rd < src_q.size()) begin
        for (int i = 0; i < src_gap; i++) begin
          @(posedge clk);
          #1;
        end
        byte_data  = src_q[src_rd];
        byte_valid = 1'b1;
        @(negedge clk);
        while (!byte_ready && !src_flush) @(negedge clk);
        if (byte_ready) src_rd++;
      end
    end
  end

  // Monitor: logs symbols and counts pulses, sampled mid-cycle.
  int sym_log[$];
  int sym_cyc[$];
  int n_sof = 0, n_eof = 0, n_done = 0, n_len = 0, n_to = 0, n_busy = 0;
  int stab_bad = 0, brdy_bad = 0;
  int done_cyc = -1, to_cyc = -1;
  logic [SymW-1:0] hold_val = '0;
  bit holding = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0;
    end else begin
      if (holding && sym_data !== hold_val) stab_bad++;
      if (holding && sym_done) holding = 1'b0;
      if (sym_start) begin
        sym_log.push_back(int'(sym_data));
        sym_cyc.push_back(cyc);
        hold_val = sym_data;
        holding  = 1'b1;
      end
      if (sof_start) n_sof++;
      if (eof_start) n_eof++;
      if (len_err) n_len++;
      if (busy) n_busy++;
      if (tx_done) begin n_done++; done_cyc = cyc; end
      if (timeout_err) begin n_to++; to_cyc = cyc; holding = 1'b0; end
      if (byte_ready && (!busy || sof_start || sym_start || eof_start || tx_done)) brdy_bad++;
    end
  end

  // Frame under test and snapshot of monitor counters at its start.
  logic [7:0] fb[$];
  int b_sym, b_sof, b_eof, b_done, b_to, b_stab, b_brdy, b_len, b_busy;
  int start_cyc;

  task automatic snap();
    b_sym = sym_log.size(); b_sof = n_sof; b_eof = n_eof; b_done = n_done; b_to = n_to;
    b_stab = stab_bad; b_brdy = brdy_bad; b_len = n_len; b_busy = n_busy;
  endtask

  task automatic run_frame(input string tag, input int noise);
    bit ended;
    snap();
    foreach (fb[i]) src_q.push_back(fb[i]);
    @(posedge clk);
    #1 tx_start = 1'b1;
    tx_len    = 8'(fb.size());
    start_cyc = cyc;
    @(posedge clk);
    #1 tx_start = 1'b0;
    ended = 1'b0;
    for (int i = 0; i < 6000 && !ended; i++) begin
      @(negedge clk);
      if (noise != 0 && i == 4) begin tx_start = 1'b1; tx_len = 8'd3; end
      if (i == 5) tx_start = 1'b0;
      if (n_done > b_done || n_to > b_to) ended = 1'b1;
    end
    tx_start = 1'b0;
    chk({tag, " frame_ended"}, 32'(ended), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Expected symbol k of byte b: bits [7-SymW*k -: SymW], MSB pair first.
  function automatic int exp_sym(input logic [7:0] b, input int k);
    return (int'(b) >> (8 - SymW * (k + 1))) % (1 << SymW);
  endfunction

  task automatic check_ok(input string tag);
    int nsym;
    nsym = 8 / SymW;
    chk({tag, " n_sym"}, 32'(sym_log.size() - b_sym), 32'(nsym * fb.size()));
    for (int k = 0; k < fb.size(); k++)
      for (int j = 0; j < nsym; j++)
        if (b_sym + k * nsym + j < sym_log.size())
          chk($sformatf("%s sym%0d_%0d", tag, k, j), 32'(sym_log[b_sym + k * nsym + j]),
              32'(exp_sym(fb[k], j)));
    chk({tag, " sof_cnt"}, 32'(n_sof - b_sof), 32'd1);
    chk({tag, " eof_cnt"}, 32'(n_eof - b_eof), 32'd1);
    chk({tag, " done_cnt"}, 32'(n_done - b_done), 32'd1);
    chk({tag, " to_cnt"}, 32'(n_to - b_to), 32'd0);
    chk({tag, " sym_stable"}, 32'(stab_bad - b_stab), 32'd0);
    chk({tag, " ready_fetch_only"}, 32'(brdy_bad - b_brdy), 32'd0);
    chk({tag, " idle_after"}, {30'd0, busy, byte_ready}, 32'd0);
  endtask

  task automatic set_delays(input int dmin, input int dmax);
    sof_dmin = dmin; sof_dmax = dmax; sym_dmin = dmin; sym_dmax = dmax;
    eof_dmin = dmin; eof_dmax = dmax;
  endtask

  task automatic flush_src();
    src_flush = 1'b1;
    repeat (4) @(negedge clk);
    src_flush = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; tx_start = 1'b0; tx_len = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_outputs", outs(), 32'd0);

    // Single byte 0xB4, every done pulse 3 cycles after its trigger.
    set_delays(3, 3); src_gap = 0;
    fb = '{8'hB4};
    run_frame("b4", 0);
    check_ok("b4");

    // Three bytes with the source gapped by 5 cycles.
    set_delays(0, 2); src_gap = 5;
    fb = '{8'h00, 8'hFF, 8'h5A};
    run_frame("three", 0);
    check_ok("three");

    // Zero-length request: error pulse only.
    snap();
    @(posedge clk);
    #1 tx_start = 1'b1; tx_len = 8'd0;
    @(posedge clk);
    #1 tx_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("len0 len_err_cnt", 32'(n_len - b_len), 32'd1);
    chk("len0 busy_cycles", 32'(n_busy - b_busy), 32'd0);
    chk("len0 triggers", 32'(n_sof - b_sof + sym_log.size() - b_sym), 32'd0);

    // Randomized frames; odd ones also get a tx_start while busy.
    for (int f = 0; f < 6; f++) begin
      set_delays(0, $urandom_range(4, 0));
      src_gap = $urandom_range(3, 0);
      n = $urandom_range(6, 1);
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", f), f % 2);
      check_ok($sformatf("rnd%0d", f));
    end

    // Minimum latency with zero-latency downstream blocks: 6 + 9n cycles inclusive.
    set_delays(0, 0); src_gap = 0;
    n = $urandom_range(4, 1);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    run_frame("lat", 0);
    check_ok("lat");
    chk("lat tx_done_cycle", 32'(done_cyc - start_cyc), 32'(5 + 9 * n));

    // Watchdog: withhold sym_done for byte 1 symbol 2.
    set_delays(0, 2); src_gap = 0;
    sp_hold = 1'b1; sp_idx = sym_seen + 6;
    fb = '{8'h3C, 8'hA5, 8'h96};
    run_frame("tmo", 0);
    chk("tmo to_cnt", 32'(n_to - b_to), 32'd1);
    chk("tmo to_latency", 32'(to_cyc - (sym_cyc[sym_cyc.size() - 1] + 1)), 32'(Timeout));
    chk("tmo n_sym", 32'(sym_log.size() - b_sym), 32'd7);
    chk("tmo no_eof", 32'(n_eof - b_eof), 32'd0);
    chk("tmo no_done", 32'(n_done - b_done), 32'd0);
    chk("tmo idle", {30'd0, busy, byte_ready}, 32'd0);
    sp_hold = 1'b0; sp_idx = -1;
    flush_src();

    // sym_done lands exactly in the expiry cycle: frame must carry on.
    sp_idx = sym_seen + 5; sp_delay = Timeout - 1;
    fb = '{8'hE1, 8'h4B};
    run_frame("edge", 0);
    check_ok("edge");
    sp_idx = -1;

    // Reset during SYM_WAIT, then a stale sym_done while idle, then a clean frame.
    set_delays(3, 3); src_gap = 0;
    snap();
    src_q.push_back(8'hC6);
    @(posedge clk);
    #1 tx_start = 1'b1; tx_len = 8'd1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    for (int i = 0; i < 60 && sym_log.size() == b_sym; i++) @(negedge clk);
    chk("rst reached_sym", 32'(sym_log.size() - b_sym), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("rst async_outputs", outs(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    snap();
    repeat (8) @(negedge clk);
    chk("rst stale_ignored", 32'(n_busy - b_busy + sym_log.size() - b_sym + n_to - b_to), 32'd0);
    fb = '{8'h1B};
    run_frame("post_rst", 0);
    check_ok("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
